// File: rtl/stack_pkg.sv
// Shared definitions for the stack master and its stack peer:
// command encodings, default depth and the master FSM state enum.
package stack_pkg;

    localparam int DEFAULT_DEPTH = 8;

    // Command encoding on the host request and on the stack peer port
    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_CLR  = 2'b01,
        CMD_PUSH = 2'b10,
        CMD_POP  = 2'b11
    } stk_cmd_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_CAPT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/stack_master.sv
// stack_master: single-transaction host-to-stack bridge with a mirrored
// occupancy counter. All outputs are registered.
// Optional macro STACK_MASTER_GUARD_EN: PUSH when full / POP when empty is
// rejected locally (never forwarded to the peer) and answered one cycle early.
module stack_master
    import stack_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int DW    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [DW-1:0]              req_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DW-1:0]              rsp_data,
    output logic                       rsp_err,
    output logic [1:0]                 stk_cmd,
    output logic [DW-1:0]              stk_data_in,
    input  logic [DW-1:0]              stk_data_out,
    input  logic                       stk_full,
    input  logic                       stk_empty,
    input  logic                       stk_error,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int            LW      = $clog2(DEPTH+1);
    localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

    state_e          r_state,       w_state_nxt;
    logic            r_req_ready,   w_req_ready_nxt;
    logic            r_rsp_valid,   w_rsp_valid_nxt;
    logic [DW-1:0]   r_rsp_data,    w_rsp_data_nxt;
    logic            r_rsp_err,     w_rsp_err_nxt;
    stk_cmd_e        r_stk_cmd,     w_stk_cmd_nxt;
    logic [DW-1:0]   r_stk_data_in, w_stk_data_in_nxt;
    logic [LW-1:0]   r_level,       w_level_nxt;
    stk_cmd_e        r_op,          w_op_nxt;
    logic            r_pred_ok,     w_pred_ok_nxt;
    stk_cmd_e        w_req_op;

    assign w_req_op    = stk_cmd_e'(req_op);
    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign stk_cmd     = r_stk_cmd;
    assign stk_data_in = r_stk_data_in;
    assign level       = r_level;

    // State and output registers; reset drops any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_INIT;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
            r_stk_cmd     <= CMD_NOP;
            r_stk_data_in <= '0;
            r_level       <= '0;
            r_op          <= CMD_NOP;
            r_pred_ok     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_data    <= w_rsp_data_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_stk_cmd     <= w_stk_cmd_nxt;
            r_stk_data_in <= w_stk_data_in_nxt;
            r_level       <= w_level_nxt;
            r_op          <= w_op_nxt;
            r_pred_ok     <= w_pred_ok_nxt;
        end
    end

    // Next-state and next-output decode; the stack command is a one-cycle pulse
    always_comb begin
        w_state_nxt       = r_state;
        w_req_ready_nxt   = r_req_ready;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_data_nxt    = r_rsp_data;
        w_rsp_err_nxt     = r_rsp_err;
        w_stk_cmd_nxt     = CMD_NOP;
        w_stk_data_in_nxt = '0;
        w_level_nxt       = r_level;
        w_op_nxt          = r_op;
        w_pred_ok_nxt     = r_pred_ok;
        case (r_state)
            ST_INIT: begin
                // The peer has no reset: send one CLR, then open for requests
                w_level_nxt = '0;
                if (r_stk_cmd == CMD_CLR) begin
                    w_state_nxt     = ST_IDLE;
                    w_req_ready_nxt = 1'b1;
                end else begin
                    w_stk_cmd_nxt   = CMD_CLR;
                end
            end
            ST_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_op_nxt        = w_req_op;
                    w_req_ready_nxt = 1'b0;
                    w_pred_ok_nxt   = !((w_req_op == CMD_PUSH && r_level == LVL_MAX) ||
                                        (w_req_op == CMD_POP  && r_level == '0));
                    if (w_req_op == CMD_NOP) begin
                        w_state_nxt     = ST_RESP;
                        w_rsp_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = ST_ISSUE;
                        w_stk_cmd_nxt = w_req_op;
`ifdef STACK_MASTER_GUARD_EN
                        if (!w_pred_ok_nxt) w_stk_cmd_nxt = CMD_NOP;
`endif
                        if (w_stk_cmd_nxt == CMD_PUSH) w_stk_data_in_nxt = req_data;
                    end
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_CAPT;
                case (r_op)
                    CMD_PUSH: if (r_level != LVL_MAX) w_level_nxt = r_level + 1'b1;
                    CMD_POP:  if (r_level != '0)      w_level_nxt = r_level - 1'b1;
                    CMD_CLR:  w_level_nxt = '0;
                    default:  ;
                endcase
`ifdef STACK_MASTER_GUARD_EN
                if (!r_pred_ok) begin
                    w_state_nxt     = ST_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_level_nxt     = r_level;
                end
`endif
            end
            ST_CAPT: begin
                w_state_nxt     = ST_RESP;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = stk_error;
                w_rsp_data_nxt  = (r_op == CMD_POP) ? stk_data_out : '0;
                // Peer disagrees with our mirror: trust its status flags
                if (stk_error && r_pred_ok)
                    w_level_nxt = stk_full ? LVL_MAX : (stk_empty ? '0 : r_level);
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_data_nxt  = '0;
                    w_rsp_err_nxt   = 1'b0;
                    w_req_ready_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

endmodule

// File: tb/tb_stack_master.sv
// Bench for stack_master with a behavioural stack peer and a response
// scoreboard. Honors STACK_MASTER_GUARD_EN for the expected error path.
module tb_stack_master;
    import stack_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
`ifdef STACK_MASTER_GUARD_EN
    localparam bit G = 1'b1;
`else
    localparam bit G = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]    req_op, stk_cmd;
    logic [DW-1:0] req_data, rsp_data, stk_data_in, stk_data_out;
    logic          stk_full, stk_empty, stk_error;
    logic [3:0]    level;

    stack_master #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .stk_cmd(stk_cmd), .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
        .stk_full(stk_full), .stk_empty(stk_empty), .stk_error(stk_error), .level(level)
    );

    always #5 clk = ~clk;

    // Stack peer: no reset, cleared only by CLR
    logic [DW-1:0] mem [DEPTH];
    logic [3:0]    sp = 4'd0;
    assign stk_full  = (sp == 4'(DEPTH));
    assign stk_empty = (sp == 4'd0);
    always @(posedge clk) begin
        stk_error <= 1'b0;
        case (stk_cmd)
            2'b01: sp <= 4'd0;
            2'b10: if (sp == 4'(DEPTH)) stk_error <= 1'b1;
                   else begin mem[sp[2:0]] <= stk_data_in; sp <= sp + 4'd1; end
            2'b11: if (sp == 4'd0) begin stk_error <= 1'b1; stk_data_out <= '0; end
                   else begin stk_data_out <= mem[sp[2:0] - 3'd1]; sp <= sp - 4'd1; end
            default: ;
        endcase
    end

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        logic [3:0]    l;
        int            lat;
    } exp_t;
    exp_t sb[$];

    int cmps = 0, errs = 0;
    int cyc = 0, acc_cyc = 0, nrsp = 0, cmd_cnt = 0;
    bit in_rsp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmps++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: latency, data-in hygiene, and scoreboard pop on handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            in_rsp = 1'b0;
        end else begin
            if (stk_cmd != 2'b00) cmd_cnt++;
            if (stk_cmd != 2'b00 && stk_cmd != 2'b10) chk("stk_data_in_zero", stk_data_in, 0);
            if (req_valid && req_ready) acc_cyc = cyc;
            if (rsp_valid && !in_rsp) begin
                in_rsp = 1'b1;
                if (sb.size() > 0) chk("rsp_latency", cyc - acc_cyc, sb[0].lat);
            end
            if (rsp_valid && rsp_ready) begin
                in_rsp = 1'b0;
                nrsp++;
                if (sb.size() == 0) begin
                    cmps++; errs++;
                    $display("FAIL unexpected_rsp: got data %0h err %0b want none", rsp_data, rsp_err);
                end else begin
                    chk("rsp_data",  rsp_data, sb[0].d);
                    chk("rsp_err",   rsp_err,  sb[0].e);
                    chk("rsp_level", level,    sb[0].l);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [7:0] ed,
                         input logic ee, input logic [3:0] el, input int lat,
                         input int ncmd, input int stall);
        int n, r0, c0;
        exp_t x;
        n = 0;
        while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
        chk("req_ready_wait", req_ready, 1);
        if (!req_ready) return;
        x.d = ed; x.e = ee; x.l = el; x.lat = lat;
        sb.push_back(x);
        r0 = nrsp; c0 = cmd_cnt;
        if (stall > 0) rsp_ready = 1'b0;
        req_valid = 1'b1; req_op = op; req_data = d;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 2'b00; req_data = '0;
        if (stall > 0) begin
            n = 0;
            while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
            for (int i = 0; i < stall; i++) begin
                chk("stall_valid", rsp_valid, 1);
                chk("stall_data",  rsp_data,  ed);
                chk("stall_ready", req_ready, 0);
                @(posedge clk); #1;
            end
            rsp_ready = 1'b1;
        end
        n = 0;
        while (nrsp == r0 && n < 40) begin @(posedge clk); #1; n++; end
        chk("rsp_seen", nrsp - r0, 1);
        chk("stk_cmd_cycles", cmd_cnt - c0, ncmd);
    endtask

    // Called right after rst_n is released (#1 past an edge)
    task automatic after_release();
        @(posedge clk); #1;
        chk("init_clr", stk_cmd, 2'b01);
        chk("init_ready_low", req_ready, 0);
        @(posedge clk); #1;
        chk("init_nop", stk_cmd, 2'b00);
        chk("init_ready", req_ready, 1);
        chk("init_level", level, 0);
    endtask

    initial begin
        int r0;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_data = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data",  rsp_data, 0);
        chk("rst_rsp_err",   rsp_err, 0);
        chk("rst_stk_cmd",   stk_cmd, 0);
        chk("rst_stk_din",   stk_data_in, 0);
        chk("rst_level",     level, 0);
        rst_n = 1'b1;
        after_release();

        // op, data, exp data, exp err, exp level, latency, stack cmds, stall
        issue(2'b10, 8'h01, 8'h00, 0, 4'd1, 3, 1, 0);
        issue(2'b10, 8'h02, 8'h00, 0, 4'd2, 3, 1, 0);
        issue(2'b11, 8'h00, 8'h02, 0, 4'd1, 3, 1, 0);
        issue(2'b11, 8'h00, 8'h01, 0, 4'd0, 3, 1, 0);
        issue(2'b11, 8'h00, 8'h00, 1, 4'd0, G ? 2 : 3, G ? 0 : 1, 0);
        issue(2'b00, 8'hAA, 8'h00, 0, 4'd0, 1, 0, 0);

        for (int i = 0; i < 8; i++)
            issue(2'b10, 8'(8'h03 + i), 8'h00, 0, 4'(i + 1), 3, 1, 0);
        issue(2'b10, 8'h0B, 8'h00, 1, 4'd8, G ? 2 : 3, G ? 0 : 1, 0);
        issue(2'b11, 8'h00, 8'h0A, 0, 4'd7, 3, 1, 5);
        issue(2'b01, 8'h00, 8'h00, 0, 4'd0, 3, 1, 0);

        issue(2'b10, 8'h10, 8'h00, 0, 4'd1, 3, 1, 0);
        issue(2'b01, 8'h00, 8'h00, 0, 4'd0, 3, 1, 0);
        issue(2'b10, 8'h20, 8'h00, 0, 4'd1, 3, 1, 0);
        issue(2'b11, 8'h00, 8'h20, 0, 4'd0, 3, 1, 0);

        // Reset pulse while a POP is in ISSUE: no response, INIT clears the peer
        issue(2'b10, 8'h55, 8'h00, 0, 4'd1, 3, 1, 0);
        r0 = nrsp;
        req_valid = 1'b1; req_op = 2'b11;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 2'b00;
        chk("mid_issue_cmd", stk_cmd, 2'b11);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_cmd", stk_cmd, 0);
        chk("mid_rst_level", level, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        after_release();
        repeat (4) @(posedge clk);
        #1;
        chk("no_rsp_after_reset", nrsp - r0, 0);
        issue(2'b11, 8'h00, 8'h00, 1, 4'd0, G ? 2 : 3, G ? 0 : 1, 0);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", cmps);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stack_master.md
STACK_MASTER -- requirements
Module: stack_master

Interface
REQ-001 Parameter DEPTH, default 8, stack entry count mirrored by the occupancy counter.
REQ-002 Parameter DW, default 8, data width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_ready  output  1  master can accept a request.
REQ-007 req_op  input  2  host operation, stack encoding: NOP 00, CLR 01, PUSH 10, POP 11.
REQ-008 req_data  input  DW  push data.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  host accepts response.
REQ-011 rsp_data  output  DW  popped data; 0 for non-POP.
REQ-012 rsp_err  output  1  operation failed.
REQ-013 stk_cmd  output  2  command to stack peer.
REQ-014 stk_data_in  output  DW  push data to stack peer.
REQ-015 stk_data_out  input  DW  stack read data, valid the cycle after the POP edge.
REQ-016 stk_full, stk_empty, stk_error  input  1 each  stack status flags.
REQ-017 level  output  $clog2(DEPTH+1)  mirrored occupancy.

Function
REQ-018 FSM states INIT, IDLE, ISSUE, CAPT, RESP; all outputs registered.
REQ-019 INIT: stk_cmd=CLR for one cycle, level<=0, then IDLE.
REQ-020 IDLE: req_ready=1, stk_cmd=NOP; req_valid&req_ready on edge E0 accepts op/data.
REQ-021 Accepted NOP: no stack command, go directly to RESP, rsp_err=0.
REQ-022 ISSUE (after E0): stk_cmd=op, stk_data_in=req_data for exactly one cycle; level updated at E1: PUSH +1, POP -1, CLR 0.
REQ-023 CAPT (after E1): stk_cmd=NOP; at E2 capture stk_data_out (POP only) and stk_error into rsp_data/rsp_err.
REQ-024 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_valid&rsp_ready, then IDLE; rsp_valid first high 3 cycles after accept.
REQ-025 Only one transaction in flight; req_ready=0 in all states except IDLE.
REQ-026 level saturates at 0 and DEPTH; never wraps.
REQ-027 stk_data_in driven 0 whenever stk_cmd is not PUSH.
REQ-028 If stk_error=1 at E2 while local check predicted success, rsp_err=1 and level resynchronised next cycle: DEPTH if stk_full, 0 if stk_empty.

Reset
REQ-029 rst_n low: state INIT, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, stk_cmd=NOP, stk_data_in=0, level=0.
REQ-030 Reset mid-transaction drops the transaction with no response; after release INIT clears the stack peer, which has no reset of its own.

Configuration
REQ-031 Macro STACK_MASTER_GUARD_EN defined: PUSH at level==DEPTH or POP at level==0 is not forwarded (stk_cmd stays NOP, level unchanged) and goes ISSUE->RESP with rsp_err=1 one cycle earlier.
REQ-032 Macro undefined: all ops forwarded; rsp_err solely from stk_error at E2.

Structure
REQ-033 Shared package stack_pkg holds command encodings, DEFAULT_DEPTH=8 and the FSM state enum; the stack peer uses the same encodings.
REQ-034 No sub-module; the stack itself is instantiated only in the bench.

Verification
REQ-035 Reset release -> one CLR cycle on stk_cmd, level=0, req_ready=1 on the second cycle.
REQ-036 PUSH 01, PUSH 02, POP, POP -> rsp_data 02 then 01, rsp_err=0, level 1,2,1,0.
REQ-037 POP at level 0 -> rsp_err=1; with GUARD_EN stk_cmd stays NOP, without it stk_cmd=POP for one cycle.
REQ-038 Push 03..0B (9 bytes) -> 9th response rsp_err=1, level=8; then POP -> rsp_data 0A.
REQ-039 rsp_ready held low 5 cycles after POP -> rsp_valid/rsp_data stable, req_ready=0 throughout.
REQ-040 PUSH 10, CLR, PUSH 20, POP -> rsp_data 20, level 0; rst_n pulse during ISSUE of a POP -> no response, INIT CLR follows.
